// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator and checker.
// Mode encodings, polynomial lengths, tap masks and FSM states.
package prbs_pkg;

  localparam int unsigned STATE_W = 31;

  typedef enum logic [1:0] {
    PRBS7  = 2'd0,
    PRBS13 = 2'd1,
    PRBS15 = 2'd2,
    PRBS31 = 2'd3
  } prbs_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fsm_e;

  localparam int unsigned LEN7  = 7;
  localparam int unsigned LEN13 = 13;
  localparam int unsigned LEN15 = 15;
  localparam int unsigned LEN31 = 31;

  // Bit k-1 set for each x^k feedback term (k >= 1).
  localparam logic [STATE_W-1:0] TAP7  = 31'h0000_0060;
  localparam logic [STATE_W-1:0] TAP13 = 31'h0000_1803;
  localparam logic [STATE_W-1:0] TAP15 = 31'h0000_6000;
  localparam logic [STATE_W-1:0] TAP31 = 31'h4800_0000;

  function automatic int unsigned poly_len(prbs_mode_e m);
    poly_len = LEN31;
    case (m)
      PRBS7:   poly_len = LEN7;
      PRBS13:  poly_len = LEN13;
      PRBS15:  poly_len = LEN15;
      default: poly_len = LEN31;
    endcase
  endfunction

  function automatic logic [STATE_W-1:0] tap_mask(prbs_mode_e m);
    tap_mask = TAP31;
    case (m)
      PRBS7:   tap_mask = TAP7;
      PRBS13:  tap_mask = TAP13;
      PRBS15:  tap_mask = TAP15;
      default: tap_mask = TAP31;
    endcase
  endfunction

  function automatic logic [STATE_W-1:0] len_mask(prbs_mode_e m);
    len_mask = STATE_W'((64'd1 << poly_len(m)) - 64'd1);
  endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// Combinational DATA_W-step Fibonacci LFSR advance.
// Shared between the transmit generator and the receive checker.
module prbs_lfsr_step
  import prbs_pkg::*;
#(
  parameter int unsigned DATA_W = 13
)(
  input  logic [STATE_W-1:0] state_i,
  input  prbs_mode_e         mode_i,
  output logic [STATE_W-1:0] state_o,
  output logic [DATA_W-1:0]  bits_o
);

  logic [STATE_W-1:0] mask;
  logic [STATE_W-1:0] taps;
  logic [STATE_W-1:0] s;
  logic [4:0]         msb;

  always_comb begin
    mask   = len_mask(mode_i);
    taps   = tap_mask(mode_i);
    msb    = 5'(poly_len(mode_i) - 1);
    s      = state_i & mask;
    bits_o = '0;
    // Earliest bit ends up in the MSB of the word.
    for (int i = 0; i < DATA_W; i++) begin
      bits_o = DATA_W'({bits_o, s[msb]});
      s      = {s[STATE_W-2:0], ^(s & taps)} & mask;
    end
    state_o = s;
  end

endmodule

// File: rtl/prbs_multi_gen.sv
// Multi-polynomial PRBS word generator with valid/ready output.
// Optional bit-error injection: define PRBS_ERR_INJECT_EN.
module prbs_multi_gen
  import prbs_pkg::*;
#(
  parameter int unsigned        DATA_W     = 13,
  parameter logic [STATE_W-1:0] SEED       = 31'h7FFF_FFFF,
  parameter int unsigned        INJ_PERIOD = 1000
)(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic              reseed,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] pattern,
  output logic              lockup,
  input  logic              inj_en,
  output logic              inj_pulse
);

  fsm_e               fsm_q, fsm_d;
  prbs_mode_e         mode_q, mode_d;
  prbs_mode_e         step_mode;
  logic               start_q;
  logic [STATE_W-1:0] lfsr_q, lfsr_d;
  logic [STATE_W-1:0] seed_m, step_in, step_out;
  logic [DATA_W-1:0]  pat_q, pat_d, step_bits;
  logic               valid_q, valid_d;
  logic               lock_q, lock_d;
  logic               word_ld, xfer, inv;

  assign seed_m    = SEED & len_mask(prbs_mode_e'(mode));
  assign step_mode = (fsm_q == LOAD) ? prbs_mode_e'(mode) : mode_q;
  assign xfer      = valid_q & out_ready;

  // LOAD generates the first word straight from the (repaired) seed.
  assign step_in = (fsm_q != LOAD) ? lfsr_q :
                   (seed_m == '0)  ? len_mask(prbs_mode_e'(mode)) :
                                     seed_m;

  prbs_lfsr_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .state_i(step_in),
    .mode_i (step_mode),
    .state_o(step_out),
    .bits_o (step_bits)
  );

  always_comb begin
    fsm_d   = fsm_q;
    mode_d  = mode_q;
    lfsr_d  = lfsr_q;
    pat_d   = pat_q;
    valid_d = valid_q;
    lock_d  = lock_q;
    word_ld = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        valid_d = 1'b0;
        if (!stop && start_q) fsm_d = LOAD;
      end
      LOAD: begin
        if (stop) begin
          fsm_d   = IDLE;
          valid_d = 1'b0;
        end else begin
          fsm_d   = RUN;
          mode_d  = prbs_mode_e'(mode);
          lfsr_d  = step_out;
          pat_d   = step_bits;
          valid_d = 1'b1;
          word_ld = 1'b1;
          lock_d  = lock_q | (seed_m == '0);
        end
      end
      RUN: begin
        if (stop) begin
          fsm_d   = IDLE;
          valid_d = 1'b0;
        end else if (reseed) begin
          fsm_d   = LOAD;
          valid_d = 1'b0;
        end else if (lfsr_q == '0) begin
          lfsr_d  = len_mask(mode_q);
          lock_d  = 1'b1;
          valid_d = 1'b0;
        end else if (!valid_q || out_ready) begin
          lfsr_d  = step_out;
          pat_d   = step_bits;
          valid_d = 1'b1;
          word_ld = 1'b1;
        end
      end
      default: begin
        fsm_d   = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q   <= IDLE;
      mode_q  <= PRBS7;
      start_q <= 1'b0;
      lfsr_q  <= '0;
      pat_q   <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      mode_q  <= mode_d;
      start_q <= start & ~stop;
      lfsr_q  <= lfsr_d;
      pat_q   <= pat_d ^ DATA_W'(inv);
      valid_q <= valid_d;
      lock_q  <= lock_d;
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  localparam logic [31:0] LAST = 32'(INJ_PERIOD - 1);

  logic [31:0] cnt_q, cnt_d;
  logic        flip_q, flip_d;

  // flip marks the presented word as carrying an inverted bit 0.
  always_comb begin
    cnt_d  = cnt_q;
    flip_d = flip_q;
    if (fsm_d != RUN) begin
      cnt_d  = '0;
      flip_d = 1'b0;
    end else if (word_ld) begin
      flip_d = 1'b0;
      if (xfer && inj_en) begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 32'd1;
        flip_d = (cnt_d == LAST);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      flip_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flip_q <= flip_d;
    end
  end

  assign inv       = word_ld & flip_d;
  assign inj_pulse = flip_q & xfer;
`else
  logic unused_inj;

  assign unused_inj = inj_en ^ (INJ_PERIOD == 0);
  assign inv        = 1'b0;
  assign inj_pulse  = 1'b0;
`endif

  assign out_valid = valid_q;
  assign pattern   = pat_q;
  assign lockup    = lock_q;

endmodule

// File: tb/tb_prbs_multi_gen.sv
// Directed bench for prbs_multi_gen: four instances cover
// DATA_W=13/1/31 and a zero seed, checked against a bit model.
module tb_prbs_multi_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [1:0] mode = 2'd0;
  logic reseed = 1'b0;
  logic out_ready = 1'b1;
  logic inj_en = 1'b0;

  logic        val_a, lock_a, inj_a;
  logic [12:0] pat_a;
  logic        val_b, lock_b, inj_b;
  logic [0:0]  pat_b;
  logic        val_z, lock_z, inj_z;
  logic [12:0] pat_z;
  logic        val_c, lock_c, inj_c;
  logic [30:0] pat_c;

  int errs = 0;
  int checks = 0;

  logic [30:0] ms;
  int          mn;
  logic [31:0] w;
  logic [30:0] w31 [1000];
  logic        bits1 [254];
  int          cnt;

  always #5 clock = ~clock;

  prbs_multi_gen #(.DATA_W(13), .INJ_PERIOD(4)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .mode(mode), .reseed(reseed), .out_ready(out_ready),
    .out_valid(val_a), .pattern(pat_a), .lockup(lock_a),
    .inj_en(inj_en), .inj_pulse(inj_a)
  );

  prbs_multi_gen #(.DATA_W(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .mode(mode), .reseed(reseed), .out_ready(out_ready),
    .out_valid(val_b), .pattern(pat_b), .lockup(lock_b),
    .inj_en(inj_en), .inj_pulse(inj_b)
  );

  prbs_multi_gen #(.DATA_W(13), .SEED(31'h0)) dutz (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .mode(mode), .reseed(reseed), .out_ready(out_ready),
    .out_valid(val_z), .pattern(pat_z), .lockup(lock_z),
    .inj_en(inj_en), .inj_pulse(inj_z)
  );

  prbs_multi_gen #(.DATA_W(31)) dut31 (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .mode(2'd3), .reseed(reseed), .out_ready(1'b1),
    .out_valid(val_c), .pattern(pat_c), .lockup(lock_c),
    .inj_en(inj_en), .inj_pulse(inj_c)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference LFSR written directly from the polynomials.
  task automatic mword(input int nb, output logic [31:0] word);
    logic b, fb;
    word = '0;
    for (int i = 0; i < nb; i++) begin
      b = ms[mn-1];
      case (mn)
        7:       fb = ms[6] ^ ms[5];
        13:      fb = ms[12] ^ ms[11] ^ ms[1] ^ ms[0];
        15:      fb = ms[14] ^ ms[13];
        default: fb = ms[30] ^ ms[27];
      endcase
      ms = {ms[29:0], fb} & 31'((32'h1 << mn) - 1);
      word = {word[30:0], b};
    end
  endtask

  task automatic start_run(input logic [1:0] m);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #3 reset = 1'b0;
    tick();
    tick();
    check("rst_valid", {val_a, val_b, val_z, val_c}, 0);
    check("rst_pattern", pat_a, 0);
    check("rst_pattern_w", {pat_b, pat_z, pat_c}, 0);
    check("rst_lockup", {lock_a, lock_b, lock_z, lock_c}, 0);
    check("rst_inj", {inj_a, inj_b, inj_z, inj_c}, 0);
    reset = 1'b1;
    tick();

    // Start latency and first PRBS-7 word.
    mode = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lat_edge_n", val_a, 0);
    tick();
    check("lat_edge_n1", val_a, 0);
    tick();
    check("lat_edge_n2", val_a, 1);
    check("p7_first", pat_a, 13'h1FC0);
    check("zero_lockup", lock_z, 1);
    check("zero_first", pat_z, 13'h1FC0);
    check("seed_no_lockup", lock_a, 0);
    check("p31_valid", val_c, 1);

    ms = 31'h7F;
    mn = 7;
    for (int i = 0; i < 1000; i++) begin
      if (i < 20) begin
        mword(13, w);
        check("p7_word", pat_a, w);
      end
      if (i < 254) bits1[i] = pat_b[0];
      w31[i] = pat_c;
      tick();
    end

    cnt = 0;
    for (int i = 0; i < 127; i++)
      if (bits1[i] !== bits1[i+127]) cnt++;
    check("p7_period", cnt, 0);
    cnt = 0;
    for (int i = 0; i < 127; i++)
      if (bits1[i] === 1'b1) cnt++;
    check("p7_ones", cnt, 64);
    ms = 31'h7F;
    cnt = 0;
    for (int i = 0; i < 254; i++) begin
      mword(1, w);
      if (bits1[i] !== w[0]) cnt++;
    end
    check("p7_bit_stream", cnt, 0);

    check("p31_first", w31[0], 31'h7FFF_FFFF);
    ms = 31'h7FFF_FFFF;
    mn = 31;
    mword(31, w);
    mword(31, w);
    check("p31_second", w31[1], w);
    cnt = 0;
    for (int i = 1; i < 1000; i++)
      if (w31[i] === w31[0]) cnt++;
    check("p31_norepeat", cnt, 0);

    // PRBS-13 with random back-pressure.
    start_run(2'd1);
    ms = 31'h1FFF;
    mn = 13;
    mword(13, w);
    check("p13_first", pat_a, 13'h1FFF);
    for (int i = 0; i < 60; i++) begin
      check("stall_valid", val_a, 1);
      check("stall_word", pat_a, w);
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (out_ready) mword(13, w);
    end
    out_ready = 1'b1;

    // Mode change without reseed is ignored; reseed applies it.
    start_run(2'd0);
    ms = 31'h7F;
    mn = 7;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) mode = 2'd2;
      mword(13, w);
      check("mode_ignored", pat_a, w);
      tick();
    end
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    check("reseed_drop", val_a, 0);
    tick();
    check("reseed_valid", val_a, 1);
    ms = 31'h7FFF;
    mn = 15;
    mword(13, w);
    check("p15_first", pat_a, 13'h1FFF);
    check("p15_first_m", pat_a, w);
    tick();
    mword(13, w);
    check("p15_second", pat_a, w);

    // start and stop together in IDLE.
    stop = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    tick();
    tick();
    tick();
    check("start_stop_idle", val_a, 0);

    // Error injection.
    inj_en = 1'b1;
    start_run(2'd0);
    ms = 31'h7F;
    mn = 7;
    for (int i = 0; i < 12; i++) begin
      mword(13, w);
`ifdef PRBS_ERR_INJECT_EN
      check("inj_word", pat_a, (i % 4 == 3) ? (w ^ 32'd1) : w);
      check("inj_pulse", inj_a, (i % 4 == 3) ? 1 : 0);
`else
      check("inj_off_word", pat_a, w);
      check("inj_off_pulse", inj_a, 0);
`endif
      tick();
    end
    inj_en = 1'b0;

    // Asynchronous reset mid-run.
    check("lock_sticky", lock_z, 1);
    check("run_valid", val_a, 1);
    #2 reset = 1'b0;
    #1;
    check("async_valid", {val_a, val_c}, 0);
    check("async_pattern", pat_a, 0);
    check("async_lockup", lock_z, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
